alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port in_op  input  6  opcode.
REQ-007 SHALL have ports in_a, in_b  input  WIDTH  operands, unsigned unless stated.
REQ-008 SHALL have port out_valid  output  1  result register holds an unconsumed result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port out_result  output  WIDTH  result.
REQ-011 SHALL have ports out_zero, out_carry, out_neg, out_ovf, out_err  output  1 each  result flags.
REQ-012 SHALL have port busy  output  1  high while in MUL state.

Function
REQ-013 SHALL decode in_op: 000000 OR, 000001 NAND, 000010 NOR, 000011 AND, 000100 ADD, 000101 SUB, 000110 XOR, 000111 SHL, 001000 SHR (logical), 001001 SAR (arithmetic), 001010 MUL (low WIDTH bits of unsigned product).
REQ-014 SHALL accept a request on a rising edge where in_valid and in_ready are both high; in_op/in_a/in_b are captured at that edge.
REQ-015 SHALL drive in_ready = (state==IDLE) and (out_valid==0 or out_ready==1).
REQ-016 SHALL implement states IDLE and MUL; IDLE->MUL on accepted MUL; MUL->IDLE after the last iteration; all other accepted ops stay in IDLE.
REQ-017 Non-MUL ops SHALL have latency 1: out_valid and results update at the accepting edge itself.
REQ-018 MUL SHALL be iterative shift-add, one operand bit per cycle, with out_valid asserted at the WIDTH-th rising edge after the accepting edge; busy high for exactly those WIDTH cycles.
REQ-019 out_valid SHALL clear at an edge with out_ready high unless a new result is loaded at that same edge; a simultaneous accept-and-consume SHALL give back-to-back throughput of one op per cycle.
REQ-020 out_result and all flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 ADD/SUB SHALL wrap modulo 2^WIDTH; out_carry = carry-out for ADD, borrow (in_a < in_b unsigned) for SUB; out_ovf = two's-complement signed overflow for ADD/SUB.
REQ-022 Shift amount SHALL be the full unsigned in_b; in_b >= WIDTH gives 0 for SHL/SHR and WIDTH copies of in_a[WIDTH-1] for SAR; in_b=0 returns in_a.
REQ-023 MUL SHALL set out_carry = 1 when any bit of the 2*WIDTH product above bit WIDTH-1 is nonzero; out_ovf = 0.
REQ-024 Logic ops and shifts SHALL set out_carry = 0 and out_ovf = 0.
REQ-025 out_zero SHALL equal (out_result==0) and out_neg SHALL equal out_result[WIDTH-1] for every op.
REQ-026 Undefined opcodes SHALL complete with latency 1: out_result 0, out_err 1, out_zero 1, other flags 0; out_err = 0 for all defined ops.
REQ-027 in_valid while in_ready=0 SHALL be ignored (no capture); requester holds it.

Reset
REQ-028 rst high SHALL immediately force state IDLE, MUL counter and accumulator 0, out_valid 0, busy 0, out_result 0, all flags 0.
REQ-029 rst asserted mid-MUL SHALL abort the operation with no result ever presented; after release in_ready = 1 on the first cycle.

Verification
REQ-030 WIDTH=8: ADD a=0x7F b=0x01 -> next edge out_result 0x80, ovf 1, carry 0, neg 1, zero 0.
REQ-031 WIDTH=8: SUB a=0x00 b=0x01 -> 0xFF, carry 1, ovf 0; SAR a=0x80 b=9 -> 0xFF; SHL a=0x01 b=8 -> 0x00, zero 1.
REQ-032 WIDTH=8: MUL a=0x10 b=0x11 -> out_valid exactly 8 edges after accept, result 0x10, carry 1, busy high 8 cycles, in_ready low throughout.
REQ-033 Stream 4 ADDs with out_ready held 1 -> one result per cycle, no bubbles; then out_ready=0 for 3 cycles -> in_ready 0, result and flags frozen.
REQ-034 Opcode 111111 -> result 0, err 1, zero 1; rst pulsed 3 cycles into a MUL -> out_valid never rises, all outputs 0, in_ready 1 after release.
REQ-035 WIDTH=16 and WIDTH=32: random op/operand regression vs reference model, including MUL latency = WIDTH and shift amounts 0, WIDTH-1, WIDTH.

Source files
------------

// File: rtl/alu_mc_if.sv
// Request/result handshake bundle for the multi-cycle ALU.
// The requester/consumer uses the master modport and the ALU uses the slave modport.
interface alu_mc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_carry;
    logic             out_neg;
    logic             out_ovf;
    logic             out_err;
    logic             busy;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_carry,
               out_neg, out_ovf, out_err, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_carry,
               out_neg, out_ovf, out_err, busy
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus an iterative shift-add
// multiplier, with a one-deep result register under valid/ready flow control.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_mc_if.slave    bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] OP_OR   = 6'd0;
    localparam logic [5:0] OP_NAND = 6'd1;
    localparam logic [5:0] OP_NOR  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_ADD  = 6'd4;
    localparam logic [5:0] OP_SUB  = 6'd5;
    localparam logic [5:0] OP_XOR  = 6'd6;
    localparam logic [5:0] OP_SHL  = 6'd7;
    localparam logic [5:0] OP_SHR  = 6'd8;
    localparam logic [5:0] OP_SAR  = 6'd9;
    localparam logic [5:0] OP_MUL  = 6'd10;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, mcand, acc_next;
    logic [WIDTH-1:0]   mplier;
    logic               accept, last, mul_done, load_en;
    logic               shift_big;
    logic [WIDTH:0]     add_full, sub_full;
    logic [WIDTH-1:0]   alu_res, load_res;
    logic               alu_carry, alu_ovf, alu_err;
    logic               load_carry, load_ovf, load_err;

    assign accept    = bus.in_valid && bus.in_ready;
    assign last      = (cnt == CW'(WIDTH - 1));
    assign mul_done  = (state == MUL) && last;
    assign acc_next  = acc + (mplier[0] ? mcand : '0);
    assign add_full  = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    assign sub_full  = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    assign shift_big = (33'(bus.in_b) >= 33'(WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && bus.in_op == OP_MUL) state_next = MUL;
            MUL:  if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A new request is only taken when the result slot is empty or being drained this edge.
    always_comb begin
        bus.busy     = (state == MUL);
        bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
    end

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (bus.in_op)
            OP_OR:   alu_res = bus.in_a | bus.in_b;
            OP_NAND: alu_res = ~(bus.in_a & bus.in_b);
            OP_NOR:  alu_res = ~(bus.in_a | bus.in_b);
            OP_AND:  alu_res = bus.in_a & bus.in_b;
            OP_XOR:  alu_res = bus.in_a ^ bus.in_b;
            OP_ADD: begin
                alu_res   = add_full[WIDTH-1:0];
                alu_carry = add_full[WIDTH];
                alu_ovf   = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                            (add_full[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = sub_full[WIDTH-1:0];
                alu_carry = sub_full[WIDTH];
                alu_ovf   = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                            (sub_full[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OP_SHL:  alu_res = shift_big ? '0 : (bus.in_a << bus.in_b);
            OP_SHR:  alu_res = shift_big ? '0 : (bus.in_a >> bus.in_b);
            OP_SAR:  alu_res = shift_big ? {WIDTH{bus.in_a[WIDTH-1]}}
                                         : $unsigned($signed(bus.in_a) >>> bus.in_b);
            OP_MUL:  alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        load_en    = mul_done || (accept && bus.in_op != OP_MUL);
        load_res   = alu_res;
        load_carry = alu_carry;
        load_ovf   = alu_ovf;
        load_err   = alu_err;
        if (mul_done) begin
            load_res   = acc_next[WIDTH-1:0];
            load_carry = |acc_next[2*WIDTH-1:WIDTH];
            load_ovf   = 1'b0;
            load_err   = 1'b0;
        end
    end

    // Shift-add multiplier: one multiplier bit is consumed per cycle, LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (accept && bus.in_op == OP_MUL) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, bus.in_a};
            mplier <= bus.in_b;
        end else if (state == MUL) begin
            cnt    <= cnt + 1'b1;
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_zero   <= 1'b0;
            bus.out_carry  <= 1'b0;
            bus.out_neg    <= 1'b0;
            bus.out_ovf    <= 1'b0;
            bus.out_err    <= 1'b0;
        end else if (load_en) begin
            bus.out_valid  <= 1'b1;
            bus.out_result <= load_res;
            bus.out_zero   <= (load_res == '0);
            bus.out_carry  <= load_carry;
            bus.out_neg    <= load_res[WIDTH-1];
            bus.out_ovf    <= load_ovf;
            bus.out_err    <= load_err;
        end else if (bus.out_ready) begin
            bus.out_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed 8-bit vectors and multi-cycle sequences,
// plus a 16/32-bit regression against a behavioural reference model.
module tb_alu_mc;
    localparam logic [5:0] OP_ADD = 6'd4;
    localparam logic [5:0] OP_SHL = 6'd7;
    localparam logic [5:0] OP_SHR = 6'd8;
    localparam logic [5:0] OP_SAR = 6'd9;
    localparam logic [5:0] OP_MUL = 6'd10;

    typedef struct packed {
        logic [5:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z, c, n, o, e;
    } vec_t;

    typedef struct packed {
        logic [31:0] result;
        logic        z, c, n, o, e;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs [23];

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(8))  bus8 ();
    alu_mc_if #(.WIDTH(16)) bus16 ();
    alu_mc_if #(.WIDTH(32)) bus32 ();

    alu_mc #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    alu_mc #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    alu_mc #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] obs8();
        return 64'({bus8.out_valid, bus8.out_result, bus8.out_zero, bus8.out_carry,
                    bus8.out_neg, bus8.out_ovf, bus8.out_err});
    endfunction

    function automatic logic [63:0] exp8(input logic v, input logic [7:0] r,
                                         input logic z, c, n, o, e);
        return 64'({v, r, z, c, n, o, e});
    endfunction

    // Reference model written with plain arithmetic on 64-bit values.
    function automatic res_t model(input logic [5:0] op, input logic [31:0] ain,
                                   input logic [31:0] bin, input int w);
        logic [63:0] mask, a, b, r, full;
        res_t        m;
        mask = (64'd1 << w) - 64'd1;
        a = 64'(ain) & mask;
        b = 64'(bin) & mask;
        r = '0;
        m = '0;
        case (op)
            6'd0: r = a | b;
            6'd1: r = ~(a & b) & mask;
            6'd2: r = ~(a | b) & mask;
            6'd3: r = a & b;
            6'd6: r = a ^ b;
            6'd4: begin
                full = a + b;
                r = full & mask;
                m.c = full[w];
                m.o = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
            end
            6'd5: begin
                r = (a - b) & mask;
                m.c = (a < b);
                m.o = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
            end
            6'd7: r = (b >= 64'(w)) ? 64'd0 : ((a << b) & mask);
            6'd8: r = (b >= 64'(w)) ? 64'd0 : (a >> b);
            6'd9: begin
                if (b >= 64'(w)) r = a[w-1] ? mask : 64'd0;
                else r = (a >> b) | (a[w-1] ? (mask & ~(mask >> b)) : 64'd0);
            end
            6'd10: begin
                full = a * b;
                r = full & mask;
                m.c = ((full >> w) != 64'd0);
            end
            default: m.e = 1'b1;
        endcase
        m.result = r[31:0];
        m.z = (r == 64'd0);
        m.n = r[w-1];
        return m;
    endfunction

    task automatic apply_stimulus(input int idx, input vec_t v);
        bus8.in_op    = v.op;
        bus8.in_a     = v.a;
        bus8.in_b     = v.b;
        bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        check_output($sformatf("vec%0d op%0h", idx, v.op), obs8(),
                     exp8(1'b1, v.res, v.z, v.c, v.n, v.o, v.e));
    endtask

    task automatic do_mul(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] r, input logic c);
        int lat = 0;
        int busy_cnt = 0;
        int ready_hi = 0;
        bus8.in_op    = OP_MUL;
        bus8.in_a     = a;
        bus8.in_b     = b;
        bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        while (!bus8.out_valid && lat < 40) begin
            if (bus8.busy) busy_cnt++;
            if (bus8.in_ready) ready_hi++;
            @(negedge clk);
            lat++;
        end
        check_output($sformatf("mul %0h*%0h latency", a, b), 64'(lat), 64'd8);
        check_output($sformatf("mul %0h*%0h busy cycles", a, b), 64'(busy_cnt), 64'd8);
        check_output($sformatf("mul %0h*%0h in_ready while busy", a, b), 64'(ready_hi), 64'd0);
        check_output($sformatf("mul %0h*%0h result", a, b), obs8(),
                     exp8(1'b1, r, r == 8'd0, c, r[7], 1'b0, 1'b0));
        check_output($sformatf("mul %0h*%0h busy after", a, b), 64'(bus8.busy), 64'd0);
    endtask

    task automatic run_wide(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t        e16, e32;
        logic [63:0] o16 = '0;
        logic [63:0] o32 = '0;
        int          lat16 = -1;
        int          lat32 = -1;
        int          k = 0;
        e16 = model(op, {16'd0, a[15:0]}, {16'd0, b[15:0]}, 16);
        e32 = model(op, a, b, 32);
        bus16.in_op = op; bus16.in_a = a[15:0]; bus16.in_b = b[15:0]; bus16.in_valid = 1'b1;
        bus32.in_op = op; bus32.in_a = a;       bus32.in_b = b;       bus32.in_valid = 1'b1;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        bus32.in_valid = 1'b0;
        while ((lat16 < 0 || lat32 < 0) && k <= 40) begin
            if (lat16 < 0 && bus16.out_valid) begin
                lat16 = k;
                o16 = 64'({16'd0, bus16.out_result, bus16.out_zero, bus16.out_carry,
                           bus16.out_neg, bus16.out_ovf, bus16.out_err});
            end
            if (lat32 < 0 && bus32.out_valid) begin
                lat32 = k;
                o32 = 64'({bus32.out_result, bus32.out_zero, bus32.out_carry,
                           bus32.out_neg, bus32.out_ovf, bus32.out_err});
            end
            if (lat16 < 0 || lat32 < 0) begin
                @(negedge clk);
                k++;
            end
        end
        check_output($sformatf("w16 op%0h a%0h b%0h latency", op, a[15:0], b[15:0]),
                     64'(lat16), (op == OP_MUL) ? 64'd16 : 64'd0);
        check_output($sformatf("w16 op%0h a%0h b%0h result", op, a[15:0], b[15:0]), o16, 64'(e16));
        check_output($sformatf("w32 op%0h a%0h b%0h latency", op, a, b),
                     64'(lat32), (op == OP_MUL) ? 64'd32 : 64'd0);
        check_output($sformatf("w32 op%0h a%0h b%0h result", op, a, b), o32, 64'(e32));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0]  s_a [5];
        logic [7:0]  s_b [5];
        logic [63:0] s_exp [5];
        int          amounts [5];
        int          seen;

        vecs[0]  = '{6'h04, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{6'h05, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{6'h09, 8'h80, 8'h09, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{6'h07, 8'h01, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{6'h04, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{6'h05, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{6'h00, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{6'h01, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{6'h02, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{6'h03, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{6'h06, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{6'h08, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{6'h08, 8'h80, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{6'h09, 8'h80, 8'h07, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{6'h09, 8'h40, 8'h00, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{6'h07, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{6'h07, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{6'h3F, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{6'h0B, 8'h55, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{6'h05, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{6'h04, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[21] = '{6'h09, 8'h7F, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{6'h07, 8'h05, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        s_a[0] = 8'h10; s_b[0] = 8'h20; s_exp[0] = exp8(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        s_a[1] = 8'h7F; s_b[1] = 8'h01; s_exp[1] = exp8(1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        s_a[2] = 8'hFF; s_b[2] = 8'h02; s_exp[2] = exp8(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        s_a[3] = 8'h00; s_b[3] = 8'h00; s_exp[3] = exp8(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        s_a[4] = 8'h05; s_b[4] = 8'h05; s_exp[4] = exp8(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        rst = 1'b1;
        bus8.in_valid  = 1'b0; bus8.in_op  = '0; bus8.in_a  = '0; bus8.in_b  = '0; bus8.out_ready  = 1'b1;
        bus16.in_valid = 1'b0; bus16.in_op = '0; bus16.in_a = '0; bus16.in_b = '0; bus16.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.in_op = '0; bus32.in_a = '0; bus32.in_b = '0; bus32.out_ready = 1'b1;
        #1;
        check_output("reset outputs", obs8(), 64'd0);
        check_output("reset busy", 64'(bus8.busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("reset in_ready", 64'(bus8.in_ready), 64'd1);

        foreach (vecs[i]) apply_stimulus(i, vecs[i]);

        do_mul(8'h10, 8'h11, 8'h10, 1'b1);
        do_mul(8'hFF, 8'hFF, 8'h01, 1'b1);
        do_mul(8'h0F, 8'h03, 8'h2D, 1'b0);
        do_mul(8'h00, 8'h5A, 8'h00, 1'b0);
        do_mul(8'h80, 8'h01, 8'h80, 1'b0);

        // Back-to-back stream, then a stalled consumer with a pending request held.
        for (int i = 0; i < 4; i++) begin
            bus8.in_op = OP_ADD; bus8.in_a = s_a[i]; bus8.in_b = s_b[i]; bus8.in_valid = 1'b1;
            @(negedge clk);
            check_output($sformatf("stream%0d result", i), obs8(), s_exp[i]);
            check_output($sformatf("stream%0d in_ready", i), 64'(bus8.in_ready), 64'd1);
        end
        bus8.out_ready = 1'b0;
        bus8.in_op = OP_ADD; bus8.in_a = s_a[4]; bus8.in_b = s_b[4]; bus8.in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_output($sformatf("stall%0d in_ready", j), 64'(bus8.in_ready), 64'd0);
            check_output($sformatf("stall%0d frozen", j), obs8(), s_exp[3]);
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        check_output("held request result", obs8(), s_exp[4]);

        // Reset three cycles into a multiply must discard it entirely.
        bus8.in_op = OP_MUL; bus8.in_a = 8'h10; bus8.in_b = 8'h11; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        check_output("mul started busy", 64'(bus8.busy), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("abort outputs", obs8(), 64'd0);
        check_output("abort busy", 64'(bus8.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("abort in_ready", 64'(bus8.in_ready), 64'd1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus8.out_valid || bus8.busy) seen++;
        end
        check_output("abort no result", 64'(seen), 64'd0);

        amounts[0] = 0; amounts[1] = 15; amounts[2] = 16; amounts[3] = 31; amounts[4] = 32;
        foreach (amounts[i]) begin
            run_wide(OP_SHL, 32'hC003_8005, 32'(amounts[i]));
            run_wide(OP_SHR, 32'hC003_8005, 32'(amounts[i]));
            run_wide(OP_SAR, 32'hC003_8005, 32'(amounts[i]));
        end
        run_wide(OP_MUL, 32'h0001_FFFF, 32'h0003_FFFF);
        run_wide(OP_MUL, 32'h0000_1234, 32'h0000_0005);
        for (int i = 0; i < 30; i++) begin
            int          r;
            logic [5:0]  op;
            logic [31:0] a, b;
            r  = $urandom_range(0, 12);
            op = (r <= 10) ? 6'(r) : ((r == 11) ? 6'h3F : 6'h0C);
            a  = $urandom;
            b  = $urandom;
            if (op == OP_SHL || op == OP_SHR || op == OP_SAR) b = 32'($urandom_range(0, 40));
            run_wide(op, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
